// File: rtl/axi4_burst_traffic_pkg.sv
// Shared types and helpers for the AXI4 burst traffic master.
// The write data pattern and the read-back check both use expected_beat().
package axi4_burst_traffic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Beat k of burst b carries b*burst_len + k + 1.
    function automatic logic [63:0] expected_beat(
        input logic [31:0] b,
        input logic [31:0] k,
        input logic [31:0] burst_len
    );
        expected_beat = {32'd0, b * burst_len + k + 32'd1};
    endfunction

endpackage

// File: rtl/axi4_burst_traffic_ctr.sv
// Burst/beat counter pair with terminal-count flags. Counts advance on their
// increment strobes only, so they hold still while the channel is stalled.
module axi4_burst_traffic_ctr #(
    parameter int BURST_LEN  = 8,
    parameter int NUM_BURSTS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       beat_inc,
    input  logic       burst_inc,
    output logic [7:0] beat,
    output logic [5:0] burst,
    output logic       beat_last,
    output logic       burst_last
);

    localparam logic [7:0] LAST_BEAT  = 8'(BURST_LEN - 1);
    localparam logic [5:0] LAST_BURST = 6'(NUM_BURSTS - 1);

    assign beat_last  = (beat == LAST_BEAT);
    assign burst_last = (burst == LAST_BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat  <= '0;
            burst <= '0;
        end else if (clr) begin
            beat  <= '0;
            burst <= '0;
        end else begin
            if (beat_inc) begin
                beat <= beat_last ? 8'd0 : beat + 8'd1;
            end
            if (burst_inc) begin
                burst <= burst_last ? 6'd0 : burst + 6'd1;
            end
        end
    end

endmodule

// File: rtl/axi4_burst_traffic_master.sv
// AXI4 master: writes NUM_BURSTS INCR bursts, reads them back and checks every beat.
// AWVALID rises 2 cycles after the INIT edge; one burst outstanding, VALIDs held until READY.
module axi4_burst_traffic_master #(
    parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000,
    parameter int          C_M_AXI_BURST_LEN          = 8,
    parameter int          C_M_AXI_ID_WIDTH           = 1,
    parameter int          C_M_AXI_ADDR_WIDTH         = 32,
    parameter int          C_M_AXI_DATA_WIDTH         = 32,
    parameter int          C_NUM_BURSTS               = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic                            INIT_AXI_TXN,
    output logic                            TXN_DONE,
    output logic                            ERROR,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [7:0]                      M_AXI_ARLEN,
    output logic [2:0]                      M_AXI_ARSIZE,
    output logic [1:0]                      M_AXI_ARBURST,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RLAST,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);
    import axi4_burst_traffic_pkg::*;

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;
    localparam logic [AW-1:0] BASE   = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
    localparam logic [AW-1:0] STRIDE = AW'(C_M_AXI_BURST_LEN * (DW / 8));

    state_t state;
    logic   init_q, issue;
    logic   awvalid, wvalid, bready, arvalid, rready, txn_done, error;
    logic   start, launch, w_fire, b_fire, r_fire, r_bad;
    logic [7:0]    wr_beat, rd_beat;
    logic [5:0]    wr_burst, rd_burst;
    logic          wr_beat_last, wr_burst_last, rd_beat_last, rd_burst_last;
    logic [DW-1:0] exp_rdata;
    logic          unused_ids;

    assign start  = INIT_AXI_TXN & ~init_q;
    assign launch = start & ((state == ST_IDLE) | (state == ST_DONE));
    assign w_fire = wvalid & M_AXI_WREADY;
    assign b_fire = bready & M_AXI_BVALID;
    assign r_fire = rready & M_AXI_RVALID;

    axi4_burst_traffic_ctr #(.BURST_LEN(C_M_AXI_BURST_LEN), .NUM_BURSTS(C_NUM_BURSTS)) u_wr_ctr (
        .clk(ACLK), .rst_n(ARESETN), .clr(launch),
        .beat_inc(w_fire), .burst_inc(b_fire),
        .beat(wr_beat), .burst(wr_burst),
        .beat_last(wr_beat_last), .burst_last(wr_burst_last)
    );

    axi4_burst_traffic_ctr #(.BURST_LEN(C_M_AXI_BURST_LEN), .NUM_BURSTS(C_NUM_BURSTS)) u_rd_ctr (
        .clk(ACLK), .rst_n(ARESETN), .clr(launch),
        .beat_inc(r_fire), .burst_inc(r_fire & rd_beat_last),
        .beat(rd_beat), .burst(rd_burst),
        .beat_last(rd_beat_last), .burst_last(rd_burst_last)
    );

    // Payloads are functions of the counters, which only move on handshakes.
    assign exp_rdata = DW'(expected_beat(32'(rd_burst), 32'(rd_beat), 32'(C_M_AXI_BURST_LEN)));
    assign r_bad     = (M_AXI_RDATA != exp_rdata) | (M_AXI_RRESP != AXI_RESP_OKAY)
                     | (M_AXI_RLAST != rd_beat_last);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= ST_IDLE;
            init_q   <= 1'b0;
            issue    <= 1'b0;
            awvalid  <= 1'b0;
            wvalid   <= 1'b0;
            bready   <= 1'b0;
            arvalid  <= 1'b0;
            rready   <= 1'b0;
            txn_done <= 1'b0;
            error    <= 1'b0;
        end else begin
            init_q <= INIT_AXI_TXN;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_WRITE;
                        issue    <= 1'b1;
                        txn_done <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (issue) begin
                        issue   <= 1'b0;
                        awvalid <= 1'b1;
                        wvalid  <= 1'b1;
                    end
                    if (awvalid && M_AXI_AWREADY) begin
                        awvalid <= 1'b0;
                    end
                    if (w_fire && wr_beat_last) begin
                        wvalid <= 1'b0;
                        bready <= 1'b1;
                    end
                    if (b_fire) begin
                        bready <= 1'b0;
                        if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                            error <= 1'b1;
                        end
                        if (wr_burst_last) begin
                            state   <= ST_READ;
                            arvalid <= 1'b1;
                            rready  <= 1'b1;
                        end else begin
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (arvalid && M_AXI_ARREADY) begin
                        arvalid <= 1'b0;
                    end
                    if (r_fire) begin
                        if (r_bad) begin
                            error <= 1'b1;
                        end
                        if (rd_beat_last) begin
                            if (rd_burst_last) begin
                                state    <= ST_DONE;
                                rready   <= 1'b0;
                                txn_done <= 1'b1;
                            end else begin
                                arvalid <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign TXN_DONE      = txn_done;
    assign ERROR         = error;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = BASE + AW'(wr_burst) * STRIDE;
    assign M_AXI_AWLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWVALID = awvalid;
    assign M_AXI_WDATA   = DW'(expected_beat(32'(wr_burst), 32'(wr_beat), 32'(C_M_AXI_BURST_LEN)));
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = wr_beat_last;
    assign M_AXI_WVALID  = wvalid;
    assign M_AXI_BREADY  = bready;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = BASE + AW'(rd_burst) * STRIDE;
    assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(DW / 8));
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARVALID = arvalid;
    assign M_AXI_RREADY  = rready;

    // Response IDs are not checked: only ID 0 is ever issued.
    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

endmodule

// File: tb/tb_axi4_burst_traffic_master.sv
// Scoreboard bench: a slave memory model answers the master; a monitor pops
// expected AW/W/AR payloads as handshakes occur and checks stall stability.
module tb_axi4_burst_traffic_master;

    localparam int L  = 8;
    localparam int NB = 4;

    logic        ACLK;
    logic        ARESETN, INIT_AXI_TXN, TXN_DONE, ERROR;
    logic [0:0]  M_AXI_AWID, M_AXI_BID, M_AXI_ARID, M_AXI_RID;
    logic [31:0] M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_RDATA;
    logic [7:0]  M_AXI_AWLEN, M_AXI_ARLEN;
    logic [2:0]  M_AXI_AWSIZE, M_AXI_ARSIZE;
    logic [1:0]  M_AXI_AWBURST, M_AXI_ARBURST, M_AXI_BRESP, M_AXI_RRESP;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WLAST, M_AXI_WVALID, M_AXI_WREADY;
    logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic        M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    axi4_burst_traffic_master dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .INIT_AXI_TXN(INIT_AXI_TXN),
        .TXN_DONE(TXN_DONE), .ERROR(ERROR),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
        .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_ar[$];
    logic [32:0] exp_w[$];
    int n_tests = 0;
    int n_fail  = 0;
    int w_seen, rl_seen, ar_seen;
    bit rand_en, corrupt_en, slverr_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input logic [31:0] val);
        n_tests++;
        n_fail++;
        $display("FAIL %s_extra: unexpected handshake with %0h, none expected", name, val);
    endtask

    function automatic logic rnd();
        return rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endfunction

    // Slave memory: drives on the falling edge, records what will handshake at the next rising edge.
    initial begin : slave
        logic [31:0] mem [0:255];
        logic [31:0] c_awaddr, c_araddr, c_wdata;
        logic        c_wlast, f_aw, f_w, f_b, f_ar, f_r, aw_have, b_pend, r_act;
        int          wptr, rptr, rleft, bcnt, rcnt;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        {f_aw, f_w, f_b, f_ar, f_r, aw_have, b_pend, r_act} = '0;
        {c_awaddr, c_araddr, c_wdata, c_wlast} = '0;
        wptr = 0; rptr = 0; rleft = 0; bcnt = 0; rcnt = 0;
        {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST} = '0;
        M_AXI_BID = '0; M_AXI_RID = '0; M_AXI_BRESP = '0; M_AXI_RRESP = '0; M_AXI_RDATA = '0;
        forever begin
            @(negedge ACLK);
            if (!ARESETN) begin
                {f_aw, f_w, f_b, f_ar, f_r, aw_have, b_pend, r_act} = '0;
                bcnt = 0; rcnt = 0;
                {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RLAST} = '0;
            end else begin
                if (f_aw) begin aw_have = 1'b1; wptr = int'(c_awaddr[9:2]); end
                if (f_w) begin
                    mem[wptr] = c_wdata;
                    wptr++;
                    if (c_wlast) b_pend = 1'b1;
                end
                if (f_b) begin M_AXI_BVALID = 1'b0; b_pend = 1'b0; aw_have = 1'b0; bcnt++; end
                if (f_ar) begin r_act = 1'b1; rptr = int'(c_araddr[9:2]); rleft = L; end
                if (f_r) begin
                    M_AXI_RVALID = 1'b0;
                    rptr++;
                    rleft--;
                    if (rleft == 0) begin r_act = 1'b0; rcnt++; end
                end
                M_AXI_AWREADY = !aw_have && rnd();
                M_AXI_WREADY  = aw_have && !b_pend && rnd();
                if (b_pend && !M_AXI_BVALID && rnd()) begin
                    M_AXI_BVALID = 1'b1;
                    M_AXI_BRESP  = (slverr_en && (bcnt % NB) == 1) ? 2'b10 : 2'b00;
                end
                M_AXI_ARREADY = !r_act && rnd();
                if (r_act && !M_AXI_RVALID && rnd()) begin
                    M_AXI_RVALID = 1'b1;
                    M_AXI_RDATA  = (corrupt_en && (rcnt % NB) == 2 && rleft == L - 5) ? 32'hDEAD : mem[rptr];
                    M_AXI_RLAST  = (rleft == 1);
                    M_AXI_RRESP  = 2'b00;
                end
                f_aw = M_AXI_AWVALID && M_AXI_AWREADY; c_awaddr = M_AXI_AWADDR;
                f_w  = M_AXI_WVALID && M_AXI_WREADY;   c_wdata = M_AXI_WDATA; c_wlast = M_AXI_WLAST;
                f_b  = M_AXI_BVALID && M_AXI_BREADY;
                f_ar = M_AXI_ARVALID && M_AXI_ARREADY; c_araddr = M_AXI_ARADDR;
                f_r  = M_AXI_RVALID && M_AXI_RREADY;
            end
        end
    end

    initial begin : monitor
        logic        p_aw, p_w;
        logic [31:0] p_addr;
        logic [32:0] p_wb;
        p_aw = 1'b0; p_w = 1'b0; p_addr = '0; p_wb = '0;
        forever begin
            @(negedge ACLK);
            #1;
            if (!ARESETN) begin
                p_aw = 1'b0;
                p_w  = 1'b0;
            end else begin
                if (p_aw) check("aw_hold", {M_AXI_AWVALID, M_AXI_AWADDR}, {1'b1, p_addr});
                if (p_w)  check("w_hold", {M_AXI_WVALID, M_AXI_WLAST, M_AXI_WDATA}, {1'b1, p_wb});
                p_aw = M_AXI_AWVALID && !M_AXI_AWREADY; p_addr = M_AXI_AWADDR;
                p_w  = M_AXI_WVALID && !M_AXI_WREADY;   p_wb = {M_AXI_WLAST, M_AXI_WDATA};
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    check("aw_fields", {M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST},
                          {1'b0, 8'd7, 3'd2, 2'b01});
                    if (exp_aw.size() == 0) extra("aw", M_AXI_AWADDR);
                    else check("aw_addr", M_AXI_AWADDR, exp_aw.pop_front());
                end
                if (M_AXI_WVALID && M_AXI_WREADY) begin
                    w_seen++;
                    if (exp_w.size() == 0) extra("w", M_AXI_WDATA);
                    else check("w_beat", {M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WDATA}, {4'hF, exp_w.pop_front()});
                end
                if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                    ar_seen++;
                    check("ar_fields", {M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST},
                          {1'b0, 8'd7, 3'd2, 2'b01});
                    if (exp_ar.size() == 0) extra("ar", M_AXI_ARADDR);
                    else check("ar_addr", M_AXI_ARADDR, exp_ar.pop_front());
                end
                if (M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST) rl_seen++;
            end
        end
    end

    task automatic push_expected();
        logic [31:0] addrs [4];
        addrs = '{32'h00, 32'h20, 32'h40, 32'h60};
        w_seen = 0; rl_seen = 0; ar_seen = 0;
        for (int b = 0; b < NB; b++) begin
            exp_aw.push_back(addrs[b]);
            exp_ar.push_back(addrs[b]);
            for (int k = 0; k < L; k++) exp_w.push_back({k == L - 1, 32'(b * L + k + 1)});
        end
    endtask

    task automatic pulse_start(input int hold);
        @(negedge ACLK);
        INIT_AXI_TXN = 1'b1;
        @(negedge ACLK);
        check("start_clear", {TXN_DONE, ERROR, M_AXI_AWVALID}, 3'b000);
        @(negedge ACLK);
        check("aw_latency", M_AXI_AWVALID, 1'b1);
        for (int i = 2; i < hold; i++) @(negedge ACLK);
        INIT_AXI_TXN = 1'b0;
    endtask

    task automatic run_seq(input int hold, input bit exp_err, input bit pulse_in_read);
        int t;
        push_expected();
        pulse_start(hold);
        if (pulse_in_read) begin
            t = 0;
            while (!M_AXI_ARVALID && t < 2000) begin @(negedge ACLK); t++; end
            check("ar_reached", M_AXI_ARVALID, 1'b1);
            INIT_AXI_TXN = 1'b1;
            repeat (2) @(negedge ACLK);
            INIT_AXI_TXN = 1'b0;
        end
        t = 0;
        while (!TXN_DONE && t < 3000) begin @(negedge ACLK); t++; end
        check("txn_done", TXN_DONE, 1'b1);
        check("error", ERROR, exp_err);
        repeat (3) @(negedge ACLK);
        check("done_held", {TXN_DONE, ERROR}, {1'b1, exp_err});
        check("w_beats", w_seen, 32);
        check("ar_bursts", ar_seen, NB);
        check("r_bursts", rl_seen, NB);
        check("queues_drained", exp_aw.size() + exp_w.size() + exp_ar.size(), 0);
    endtask

    initial begin : stimulus
        int t;
        ARESETN = 1'b0;
        INIT_AXI_TXN = 1'b0;
        rand_en = 1'b0; corrupt_en = 1'b0; slverr_en = 1'b0;
        w_seen = 0; rl_seen = 0; ar_seen = 0;
        repeat (3) @(negedge ACLK);
        check("reset_outputs", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                M_AXI_RREADY, TXN_DONE, ERROR}, 7'd0);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        check("idle_outputs", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, TXN_DONE, ERROR}, 5'd0);

        run_seq(2, 1'b0, 1'b0);

        rand_en = 1'b1;
        run_seq(2, 1'b0, 1'b0);
        rand_en = 1'b0;

        corrupt_en = 1'b1;
        run_seq(2, 1'b1, 1'b0);
        corrupt_en = 1'b0;

        slverr_en = 1'b1;
        run_seq(2, 1'b1, 1'b0);
        slverr_en = 1'b0;

        // Reset in the middle of burst 1 of the write phase.
        push_expected();
        pulse_start(2);
        t = 0;
        while (w_seen < 11 && t < 2000) begin @(negedge ACLK); t++; end
        check("mid_write_reached", M_AXI_WVALID, 1'b1);
        #2 ARESETN = 1'b0;
        #1 check("async_reset", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                                 M_AXI_RREADY, TXN_DONE, ERROR, M_AXI_AWADDR}, 39'd0);
        exp_aw.delete(); exp_w.delete(); exp_ar.delete();
        repeat (3) @(negedge ACLK);
        ARESETN = 1'b1;
        run_seq(2, 1'b0, 1'b0);

        // Long INIT plus a stray pulse during READ, then a restart from DONE.
        run_seq(10, 1'b0, 1'b1);
        run_seq(2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_burst_traffic_master.md
Name: axi4_burst_traffic_master

Overview:
- AXI4 full master that generates the test traffic consumed by the downstream AXI slave memory (slave VIP in simulation).
- A rising edge on INIT_AXI_TXN starts the sequence:
  - write NUM_BURSTS incrementing INCR bursts;
  - read the same bursts back and compare every beat;
  - report on TXN_DONE and ERROR.
- Sits on the M00_AXI port of the IP wrapper.

Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h0000_0000, byte base address of the first burst.
- C_M_AXI_BURST_LEN, 8, beats per burst (1..256); AxLEN = value-1.
- C_M_AXI_ID_WIDTH, 1, width of AWID/ARID/BID/RID; issued ID is always 0.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width (32 or 64).
- C_NUM_BURSTS, 4, bursts per phase (1..64).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- INIT_AXI_TXN  in  1  start request; rising edge is detected.
- TXN_DONE  out  1  sequence complete; held high until the next start.
- ERROR  out  1  sticky error flag; cleared on start.
- M_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  out  ID/ADDR/8/3/2  write address fields.
- M_AXI_AWVALID out 1, M_AXI_AWREADY in 1  write address handshake.
- M_AXI_WDATA/WSTRB/WLAST  out  DATA/DATA/8/1  write data fields.
- M_AXI_WVALID out 1, M_AXI_WREADY in 1  write data handshake.
- M_AXI_BID/BRESP in ID/2, M_AXI_BVALID in 1, M_AXI_BREADY out 1  write response.
- M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  out  ID/ADDR/8/3/2  read address fields.
- M_AXI_ARVALID out 1, M_AXI_ARREADY in 1  read address handshake.
- M_AXI_RID/RDATA/RRESP/RLAST in ID/DATA/2/1, M_AXI_RVALID in 1, M_AXI_RREADY out 1  read data.

Behaviour:
- Clock and reset: single clock ACLK; ARESETN asynchronous active-low.
- Reset values: all VALIDs, BREADY, RREADY, TXN_DONE, ERROR, counters and the edge-detect flop are 0; FSM is IDLE.
- Static fields: AxSIZE = clog2(DATA/8); AxBURST = INCR (2'b01); AxLEN = BURST_LEN-1; WSTRB all ones.
- Addressing: burst b uses address BASE + b*BURST_LEN*(DATA/8); addresses wrap modulo 2^ADDR.
- Data pattern: beat k of burst b carries b*BURST_LEN + k + 1, zero-extended to DATA width.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE: start = INIT_AXI_TXN & ~init_q. On start, clear TXN_DONE, ERROR and counters, then go to WRITE. A start outside IDLE/DONE is ignored.
  - WRITE: one burst outstanding at a time.
    - AWVALID rises the cycle after entering WRITE or after the previous BVALID&BREADY; it holds until AWREADY.
    - WVALID may assert together with AWVALID.
    - The beat counter advances only on WVALID&WREADY; WLAST is asserted on beat BURST_LEN-1.
    - BREADY is high from the last W beat until the B handshake.
    - BRESP != OKAY sets ERROR.
    - After burst C_NUM_BURSTS-1 completes its B handshake, go to READ.
  - READ: one burst outstanding at a time.
    - ARVALID holds until ARREADY; RREADY is high while the burst is outstanding.
    - On each RVALID&RREADY, compare RDATA with the expected pattern. ERROR is set by any of:
      - data mismatch;
      - RRESP != OKAY;
      - RLAST asserted early, or missing on beat BURST_LEN-1.
    - After the last burst's final beat, go to DONE.
  - DONE: TXN_DONE=1; ERROR is stable. A new start edge goes to WRITE and clears both flags.
- Handshake rules:
  - VALID is never withdrawn before READY.
  - Payload is stable while VALID is high and not accepted.
  - Zero-wait READY sustains one beat per cycle.
- Latency: AWVALID asserts 2 cycles after the INIT rising edge (edge-detect flop plus FSM transition).
- Reset mid-operation: all outputs return to reset values immediately. The slave may observe a truncated burst; this is acceptable in test use only.
- ERROR is sticky: once set, it stays high through DONE; the sequence still completes all bursts.

Decomposition:
- Package axi4_burst_traffic_pkg holds:
  - the state enum;
  - AXI_BURST_INCR and AXI_RESP_OKAY constants;
  - function expected_beat(b, k, burst_len).
- Sub-module axi4_burst_traffic_ctr: a burst/beat counter pair with terminal-count flags. It is instantiated once for the write side and once for the read side.

Test Plan:
- Defaults, zero-wait slave memory, 20 ns INIT pulse. Required response:
  - 4 write bursts at 0x00/0x20/0x40/0x60 with data 1..32;
  - read-back matches;
  - TXN_DONE=1, ERROR=0.
- Randomized READY backpressure on AW/W/B/AR/R channels -> identical data and addresses; VALID and payload stable while stalled; TXN_DONE=1, ERROR=0.
- Slave corrupts read beat 5 of burst 2 (expects 22; returns 0xDEAD) -> ERROR=1 at DONE; all 4 read bursts still complete.
- Slave returns SLVERR on the B of burst 1 -> ERROR=1; read phase still runs; TXN_DONE=1.
- ARESETN low for 3 cycles mid-WRITE (burst 1, beat 3) -> outputs return to 0 asynchronously. A subsequent INIT completes with ERROR=0.
- INIT held high 10 cycles, then a second pulse during READ -> exactly one sequence runs. A pulse in DONE starts a second run and clears TXN_DONE the next cycle.
